// File: rtl/operand_feeder.sv
// Front end of the a*b*cos(c)/(a+d) datapath: shifts d out serially after reset,
// then drains a small operand FIFO into registered a/b/c, one triple per clock.
module operand_feeder #(
   parameter int W     = 12,
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [W-1:0]              d_cfg,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [W-1:0]              in_a,
   input  logic [W-1:0]              in_b,
   input  logic [W-1:0]              in_c,
   output logic                      e,
   output logic [W-1:0]              a,
   output logic [W-1:0]              b,
   output logic [W-1:0]              c,
   output logic                      out_valid,
   output logic                      load_done,
   output logic [$clog2(DEPTH):0]    level,
   output logic [7:0]                issued
);

   // state  | meaning
   // S_LOAD | shifting d_cfg onto e, LSB first, W clocks; FIFO accepts but never pops
   // S_RUN  | e held low; FIFO head issued to a/b/c whenever level > 0
   localparam int AW = $clog2(DEPTH);
   localparam int CW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic {S_LOAD, S_RUN} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
   logic              load_done_q, load_done_d;
   logic [3*W-1:0]    mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]       level_q, level_d;
   logic [W-1:0]      a_q, a_d, b_q, b_d, c_q, c_d;
   logic              out_valid_q, out_valid_d;
   logic [7:0]        issued_q, issued_d;
   logic              push, pop, full, last_bit, e_raw;

   assign full     = (level_q == (AW+1)'(DEPTH));
   assign in_ready = ~full;
   assign push     = in_valid & ~full;
   assign last_bit = (bit_cnt_q == CW'(W-1));

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      load_done_d = load_done_q;
      e_raw       = 1'b0;
      pop         = 1'b0;
      out_valid_d = 1'b0;
      a_d         = a_q;
      b_d         = b_q;
      c_d         = c_q;
      issued_d    = issued_q;
      case (state_q)
         S_LOAD: begin
            e_raw = d_cfg[bit_cnt_q];
            if (last_bit) begin
               state_d     = S_RUN;
               load_done_d = 1'b1;
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         S_RUN: begin
            if (level_q != '0) begin
               pop                = 1'b1;
               out_valid_d        = 1'b1;
               {a_d, b_d, c_d}    = mem_q[rd_ptr_q];
               issued_d           = issued_q + 8'd1;
            end
         end
         default: state_d = S_LOAD;
      endcase
   end

   // e must read 0 while reset is held, even though bit_cnt already points at d_cfg[0]
   assign e = e_raw & rst;

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      level_d  = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_LOAD;
         bit_cnt_q   <= '0;
         load_done_q <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         a_q         <= '0;
         b_q         <= '0;
         c_q         <= '0;
         out_valid_q <= 1'b0;
         issued_q    <= '0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         load_done_q <= load_done_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         a_q         <= a_d;
         b_q         <= b_d;
         c_q         <= c_d;
         out_valid_q <= out_valid_d;
         issued_q    <= issued_d;
      end
   end

   // Storage needs no reset: entries are only visible through level/pointers.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {in_a, in_b, in_c};
   end

   assign a         = a_q;
   assign b         = b_q;
   assign c         = c_q;
   assign out_valid = out_valid_q;
   assign load_done = load_done_q;
   assign level     = level_q;
   assign issued    = issued_q;

endmodule

// File: tb/tb_operand_feeder.sv
// Randomised bench for operand_feeder: a queue-based reference model tracks FIFO
// occupancy and load progress; a monitor pops expected triples on every issue.
`timescale 1ns/1ps
module tb_operand_feeder;
   localparam int W     = 12;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [W-1:0]  d_cfg;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_a, in_b, in_c;
   logic          e;
   logic [W-1:0]  a, b, c;
   logic          out_valid;
   logic          load_done;
   logic [2:0]    level;
   logic [7:0]    issued;

   operand_feeder #(.W(W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .d_cfg(d_cfg), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_c(in_c), .e(e), .a(a), .b(b), .c(c),
      .out_valid(out_valid), .load_done(load_done), .level(level), .issued(issued)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [3*W-1:0] exp_q [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: occupancy is a plain count, load progress is edges since release.
   int mlevel   = 0;
   int edges    = 0;
   int pend_pop = 0;
   always @(negedge clk) begin
      int push_i, pop_i;
      logic [W-1:0] dv;
      if (!rst) begin
         exp_q.delete();
         mlevel   = 0;
         edges    = 0;
         pend_pop = 0;
      end else begin
         dv = d_cfg;
         check("out_valid", out_valid, pend_pop);
         check("level", level, mlevel);
         check("in_ready", in_ready, mlevel < DEPTH);
         check("load_done", load_done, edges >= W);
         if (edges < W) check("e_load", e, dv[edges]);
         else           check("e_run", e, 0);
         push_i = (in_valid && mlevel < DEPTH) ? 1 : 0;
         pop_i  = (edges >= W && mlevel > 0) ? 1 : 0;
         if (push_i == 1) exp_q.push_back({in_a, in_b, in_c});
         mlevel   = mlevel + push_i - pop_i;
         pend_pop = pop_i;
         if (edges < W) edges++;
      end
   end

   // Scoreboard monitor
   int             mon_issued = 0;
   logic [3*W-1:0] last_abc   = '0;
   always @(negedge clk) begin
      logic [3*W-1:0] exp_t;
      if (!rst) begin
         mon_issued = 0;
         last_abc   = '0;
      end else if (out_valid) begin
         if (exp_q.size() == 0) begin
            check("issue_unexpected", 1, 0);
         end else begin
            exp_t = exp_q.pop_front();
            check("abc", {a, b, c}, exp_t);
            last_abc = exp_t;
         end
         mon_issued = (mon_issued + 1) % 256;
         check("issued", issued, mon_issued);
      end else begin
         check("abc_hold", {a, b, c}, last_abc);
      end
   end

   int ecount = 0;

   task automatic cycle(output bit acc);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      ecount++;
   endtask

   task automatic idle(input int n);
      bit acc;
      in_valid = 1'b0;
      repeat (n) cycle(acc);
   endtask

   task automatic reset_checks();
      check("rst_e", e, 0);
      check("rst_level", level, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_abc", {a, b, c}, 0);
      check("rst_load_done", load_done, 0);
      check("rst_issued", issued, 0);
   endtask

   // Assert reset 1 ns from now, hold two edges, release 2 ns after an edge.
   task automatic do_reset(input logic [W-1:0] dnew);
      #1 rst = 1'b0;
      in_valid = 1'b0;
      #1 reset_checks();
      d_cfg = dnew;
      @(posedge clk); @(posedge clk); #2 rst = 1'b1;
      ecount = 0;
   endtask

   task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [W-1:0] tc,
                       output int acc_edge);
      bit acc;
      int guard;
      in_valid = 1'b1; in_a = ta; in_b = tb_; in_c = tc;
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 40) begin
         cycle(acc);
         guard++;
      end
      if (!acc) check("send_timeout", 0, 1);
      acc_edge = ecount;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int pat [12] = '{0,0,1,1,1,0,1,0,0,1,0,1};
      int ae;
      bit acc;
      rst = 1'b0; d_cfg = 12'hA5C; in_valid = 1'b0; in_a = '0; in_b = '0; in_c = '0;
      #12 reset_checks();

      // d load with pre-load buffering of three triples
      @(posedge clk); #2 rst = 1'b1; ecount = 0;
      for (int k = 0; k < 12; k++) begin
         if (k < 3) begin
            in_valid = 1'b1; in_a = W'(3*k+1); in_b = W'(3*k+2); in_c = W'(3*k+3);
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         check("e_pattern", e, pat[k]);
         check("ov_in_load", out_valid, 0);
         @(posedge clk); #1;
         ecount++;
      end
      check("level_after_load", level, 3);
      check("load_done_edge12", load_done, 1);
      idle(3);
      check("issued_after_15", issued, 3);
      check("level_after_15", level, 0);
      check("e_after_load", e, 0);

      // full FIFO during load: 5th triple waits for the first pop at edge 13
      do_reset(W'($urandom));
      for (int t = 0; t < 5; t++)
         send(W'($urandom), W'($urandom), W'($urandom), ae);
      check("fifth_accept_edge", ae, 14);
      idle(8);

      // single triple in RUN with empty FIFO
      send(12'h123, 12'h456, 12'h789, ae);
      in_valid = 1'b0;
      idle(5);
      check("hold_a", a, 12'h123);
      check("hold_b", b, 12'h456);
      check("hold_c", c, 12'h789);
      check("hold_ov", out_valid, 0);

      // reset mid-load at bit_cnt=6 with two triples buffered
      do_reset(W'($urandom));
      send(W'($urandom), W'($urandom), W'($urandom), ae);
      send(W'($urandom), W'($urandom), W'($urandom), ae);
      in_valid = 1'b0;
      while (ecount < 6) cycle(acc);
      check("level_before_midload_rst", level, 2);
      do_reset(W'($urandom));

      // reset mid-stream with level=2
      for (int t = 0; t < 4; t++) send(W'($urandom), W'($urandom), W'($urandom), ae);
      in_valid = 1'b0;
      while (ecount < 14) cycle(acc);
      check("level_mid_stream", level, 2);
      check("ov_mid_stream", out_valid, 1);
      do_reset(W'($urandom));

      // 300 back-to-back triples across pointer and counter wrap
      for (int t = 0; t < 300; t++)
         send(W'($urandom), W'($urandom), W'($urandom), ae);
      in_valid = 1'b0;
      idle(10);
      check("issued_wrap", issued, 44);
      check("level_drained", level, 0);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
